// File: rtl/rx_audio_unpack_pkg.sv
// Shared definitions for the rx audio frame unpacker: state encoding and
// the helper that merges the three sample words into an I/Q pair.
package rx_audio_unpack_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_S0   = 3'd1;
    localparam logic [2:0] ST_S1   = 3'd2;
    localparam logic [2:0] ST_S2   = 3'd3;
    localparam logic [2:0] ST_T0   = 3'd4;
    localparam logic [2:0] ST_T1   = 3'd5;
    localparam logic [2:0] ST_T2   = 3'd6;
    localparam logic [2:0] ST_BC   = 3'd7;

    typedef struct packed {
        logic [23:0] i;
        logic [23:0] q;
    } samp_pair_t;

    // Third sample word carries the low bytes: {I[7:0], Q[7:0]}.
    function automatic samp_pair_t assemble_pair(input logic [15:0] i_hi,
                                                 input logic [15:0] q_hi,
                                                 input logic [15:0] lo);
        return {i_hi, lo[15:8], q_hi, lo[7:0]};
    endfunction

endpackage

// File: rtl/rx_samp_outreg.sv
// Single-entry valid/ready output register for sample pairs; flags ovfl when a
// new sample starts while the previous pair is still unaccepted.
module rx_samp_outreg (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] load_i,
    input  logic [23:0] load_q,
    input  logic        w0_seen,
    input  logic        samp_ready,
    input  logic        err_clr,
    output logic        samp_valid,
    output logic [23:0] samp_i,
    output logic [23:0] samp_q,
    output logic        ovfl
);

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_valid <= 1'b0;
            samp_i     <= '0;
            samp_q     <= '0;
            ovfl       <= 1'b0;
        end else begin
            // Load beats accept, so an accept and a reload in one cycle leave no bubble.
            if (load) begin
                samp_valid <= 1'b1;
                samp_i     <= load_i;
                samp_q     <= load_q;
            end else if (samp_ready) begin
                samp_valid <= 1'b0;
            end

            if (w0_seen && samp_valid && !samp_ready)
                ovfl <= 1'b1;
            else if (err_clr)
                ovfl <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_audio_unpack.sv
// Reassembles the rx shared-memory word stream into I/Q pairs, a 48-bit tick
// timestamp and a buffer counter, one frame at a time.
module rx_audio_unpack
    import rx_audio_unpack_pkg::*;
#(
    parameter int NSAMPS_BITS = 16
) (
    input  logic                   cpu_clk,
    input  logic                   rst_n,
    input  logic                   frame_start_C,
    input  logic [NSAMPS_BITS-1:0] nsamps_C,
    input  logic                   rx_rd_C,
    input  logic [15:0]            rx_dout_C,
    output logic                   samp_valid,
    input  logic                   samp_ready,
    output logic [23:0]            samp_i,
    output logic [23:0]            samp_q,
    output logic [47:0]            ticks,
    output logic [15:0]            buf_ctr,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   ovfl,
    input  logic                   err_clr
);

    localparam logic [NSAMPS_BITS-1:0] CNT_ONE = NSAMPS_BITS'(1);

    logic [2:0]             state, state_nx;
    logic [NSAMPS_BITS-1:0] cnt, cnt_nx, cnt_dec;
    logic [15:0]            i_hi, q_hi, t0_hold, t1_hold;
    logic                   word_take;
    samp_pair_t             pair;

    // A frame start wins over a word in the same cycle; that word is dropped.
    assign word_take = rx_rd_C && !frame_start_C;
    assign cnt_dec   = cnt - CNT_ONE;
    assign pair      = assemble_pair(i_hi, q_hi, rx_dout_C);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nx = state;
        cnt_nx   = cnt;
        if (frame_start_C) begin
            state_nx = (nsamps_C == '0) ? ST_T0 : ST_S0;
            cnt_nx   = nsamps_C;
        end else if (rx_rd_C) begin
            case (state)
                ST_IDLE: state_nx = ST_IDLE;
                ST_S0:   state_nx = ST_S1;
                ST_S1:   state_nx = ST_S2;
                ST_S2: begin
                    cnt_nx   = cnt_dec;
                    state_nx = (cnt_dec != '0) ? ST_S0 : ST_T0;
                end
                ST_T0:   state_nx = ST_T1;
                ST_T1:   state_nx = ST_T2;
                ST_T2:   state_nx = ST_BC;
                ST_BC:   state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            ticks      <= '0;
            buf_ctr    <= '0;
            // NOTE: staging words are never observed before being rewritten, but reset keeps sim deterministic.
            i_hi       <= '0;
            q_hi       <= '0;
            t0_hold    <= '0;
            t1_hold    <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            busy       <= (state_nx != ST_IDLE);
            frame_done <= word_take && (state == ST_BC);
            if (word_take) begin
                case (state)
                    ST_S0:   i_hi    <= rx_dout_C;
                    ST_S1:   q_hi    <= rx_dout_C;
                    ST_T0:   t0_hold <= rx_dout_C;
                    ST_T1:   t1_hold <= rx_dout_C;
                    ST_T2:   ticks   <= {t0_hold, t1_hold, rx_dout_C};
                    ST_BC:   buf_ctr <= rx_dout_C;
                    default: ;
                endcase
            end
        end
    end

    rx_samp_outreg u_outreg (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .load       (word_take && (state == ST_S2)),
        .load_i     (pair.i),
        .load_q     (pair.q),
        .w0_seen    (word_take && (state == ST_S0)),
        .samp_ready (samp_ready),
        .err_clr    (err_clr),
        .samp_valid (samp_valid),
        .samp_i     (samp_i),
        .samp_q     (samp_q),
        .ovfl       (ovfl)
    );

endmodule

// File: tb/tb_rx_audio_unpack.sv
// Self-checking bench for rx_audio_unpack: vector table, directed corner cases
// and randomized frames checked against a window-based handshake model.
module tb_rx_audio_unpack;

    logic        cpu_clk = 1'b0;
    logic        rst_n;
    logic        frame_start_C;
    logic [15:0] nsamps_C;
    logic        rx_rd_C;
    logic [15:0] rx_dout_C;
    logic        samp_valid;
    logic        samp_ready;
    logic [23:0] samp_i;
    logic [23:0] samp_q;
    logic [47:0] ticks;
    logic [15:0] buf_ctr;
    logic        frame_done;
    logic        busy;
    logic        ovfl;
    logic        err_clr;

    rx_audio_unpack #(.NSAMPS_BITS(16)) dut (
        .cpu_clk       (cpu_clk),
        .rst_n         (rst_n),
        .frame_start_C (frame_start_C),
        .nsamps_C      (nsamps_C),
        .rx_rd_C       (rx_rd_C),
        .rx_dout_C     (rx_dout_C),
        .samp_valid    (samp_valid),
        .samp_ready    (samp_ready),
        .samp_i        (samp_i),
        .samp_q        (samp_q),
        .ticks         (ticks),
        .buf_ctr       (buf_ctr),
        .frame_done    (frame_done),
        .busy          (busy),
        .ovfl          (ovfl),
        .err_clr       (err_clr)
    );

    always #5 cpu_clk = ~cpu_clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;  // 0 hold, 1 random, 2 toggle
    int          done_cnt = 0;
    bit          ready_log [0:65535];
    logic [47:0] acc_q [$];

    // Handshake monitor: records every accepted pair and every frame_done pulse.
    always @(negedge cpu_clk) begin
        if (rst_n && samp_valid && samp_ready) acc_q.push_back({samp_i, samp_q});
        if (rst_n && frame_done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        ready_log[cyc] = samp_ready;
        @(posedge cpu_clk);
        #1;
        cyc++;
        frame_start_C = 1'b0;
        rx_rd_C       = 1'b0;
        err_clr       = 1'b0;
        if (rdy_mode == 1) samp_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) samp_ready = ~samp_ready;
    endtask

    task automatic start(input int n);
        frame_start_C = 1'b1;
        nsamps_C      = 16'(n);
        step();
    endtask

    task automatic word(input logic [15:0] w);
        rx_rd_C   = 1'b1;
        rx_dout_C = w;
        step();
    endtask

    task automatic gap(input int g);
        repeat ($urandom_range(0, g)) step();
    endtask

    task automatic sample(input logic [23:0] i, input logic [23:0] q);
        word(i[23:8]);
        word(q[23:8]);
        word({i[7:0], q[7:0]});
    endtask

    task automatic trailer(input logic [47:0] t, input logic [15:0] c);
        word(t[47:32]);
        word(t[31:16]);
        word(t[15:0]);
        word(c);
    endtask

    // Random frame; expected pairs/ovfl derived from per-pair ready windows.
    task automatic run_frame(input int n, input int gmax, input int mode);
        logic [23:0] si [$];
        logic [23:0] sq [$];
        int          w0c [$];
        int          lc [$];
        logic [47:0] exp_q [$];
        logic [47:0] t;
        logic [15:0] bc;
        int          base, d0, last;
        bit          exp_ovfl, hit;

        rdy_mode = 0; samp_ready = 1'b1; err_clr = 1'b1;
        step(); step();
        base = acc_q.size(); d0 = done_cnt;
        rdy_mode = mode;
        start(n);
        for (int k = 0; k < n; k++) begin
            si.push_back(24'($urandom()));
            sq.push_back(24'($urandom()));
            gap(gmax); w0c.push_back(cyc); word(si[k][23:8]);
            gap(gmax); word(sq[k][23:8]);
            gap(gmax); lc.push_back(cyc + 1); word({si[k][7:0], sq[k][7:0]});
        end
        t  = {16'($urandom()), 16'($urandom()), 16'($urandom())};
        bc = 16'($urandom());
        gap(gmax); word(t[47:32]); gap(gmax); word(t[31:16]);
        gap(gmax); word(t[15:0]);  gap(gmax); word(bc);
        rdy_mode = 0; samp_ready = 1'b1;
        step(); step();

        exp_ovfl = 1'b0;
        for (int k = 0; k < n; k++) begin
            last = (k + 1 < n) ? lc[k + 1] - 1 : cyc - 1;
            hit = 1'b0;
            for (int c = lc[k]; c <= last; c++) hit |= ready_log[c];
            if (hit) exp_q.push_back({si[k], sq[k]});
            if (k + 1 < n) begin
                hit = 1'b0;
                for (int c = lc[k]; c <= w0c[k + 1]; c++) hit |= ready_log[c];
                if (!hit) exp_ovfl = 1'b1;
            end
        end
        check("rnd_ovfl", 64'(ovfl), 64'(exp_ovfl));
        check("rnd_npairs", 64'(acc_q.size() - base), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < acc_q.size(); k++)
            check("rnd_pair", 64'(acc_q[base + k]), 64'(exp_q[k]));
        check("rnd_ticks", 64'(ticks), 64'(t));
        check("rnd_bufctr", 64'(buf_ctr), 64'(bc));
        check("rnd_done", 64'(done_cnt - d0), 64'd1);
    endtask

    typedef struct {
        logic [15:0] w0, w1, w2;
        logic [23:0] exp_i, exp_q;
    } vec_t;

    vec_t        vecs [4];
    int          base, d0;
    logic [47:0] tk;

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 16'h9ABC, 24'h12349A, 24'h5678BC};
        vecs[1] = '{16'hFEDC, 16'hBA98, 16'h7654, 24'hFEDC76, 24'hBA9854};
        vecs[2] = '{16'h8000, 16'h7FFF, 16'h00FF, 24'h800000, 24'h7FFFFF};
        vecs[3] = '{16'hFFFF, 16'h0000, 16'hFF00, 24'hFFFFFF, 24'h000000};

        rst_n = 1'b0; frame_start_C = 1'b0; nsamps_C = '0; rx_rd_C = 1'b0;
        rx_dout_C = '0; samp_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge cpu_clk);
        #1;
        check("rst_state", {busy, samp_valid, frame_done, ovfl}, 64'd0);
        check("rst_data", {samp_i, samp_q}, 64'd0);
        check("rst_trl", {ticks, buf_ctr}, 64'd0);
        rst_n = 1'b1;
        step();

        // Vector table: one-sample frames, ready held high.
        for (int k = 0; k < 4; k++) begin
            base = acc_q.size(); d0 = done_cnt;
            tk = 48'h0000_1111_0000 + 48'(k);
            start(1);
            word(vecs[k].w0); word(vecs[k].w1); word(vecs[k].w2);
            check("vec_valid", 64'(samp_valid), 64'd1);
            check("vec_i", 64'(samp_i), 64'(vecs[k].exp_i));
            check("vec_q", 64'(samp_q), 64'(vecs[k].exp_q));
            trailer(tk, 16'h0100 + 16'(k));
            check("vec_done", {frame_done, busy}, 64'b10);
            check("vec_ticks", 64'(ticks), 64'(tk));
            check("vec_bufctr", 64'(buf_ctr), 64'(16'h0100 + 16'(k)));
            step();
            check("vec_done_1cyc", 64'(frame_done), 64'd0);
            check("vec_npairs", 64'(acc_q.size() - base), 64'd1);
            check("vec_ndone", 64'(done_cnt - d0), 64'd1);
        end

        // Two-sample frame; ticks must not move until the third trailer word.
        base = acc_q.size(); d0 = done_cnt;
        start(2);
        check("f2_busy", 64'(busy), 64'd1);
        word(16'h1234); word(16'h5678);
        check("f2_nvalid", 64'(samp_valid), 64'd0);
        word(16'h9ABC);
        check("f2_pair0", {samp_valid, samp_i, samp_q}, {1'b1, 24'h12349A, 24'h5678BC});
        sample(24'hFEDC76, 24'hBA9854);
        word(16'h0001); word(16'h0002);
        check("f2_ticks_held", 64'(ticks), 64'h0000_1111_0003);
        word(16'h0003);
        check("f2_ticks", 64'(ticks), 64'h0001_0002_0003);
        word(16'h0042);
        check("f2_done", {frame_done, busy, buf_ctr}, {1'b1, 1'b0, 16'h0042});
        step();
        check("f2_npairs", 64'(acc_q.size() - base), 64'd2);
        if (acc_q.size() >= base + 2) begin
            check("f2_acc0", 64'(acc_q[base]), 64'h12349A_5678BC);
            check("f2_acc1", 64'(acc_q[base + 1]), 64'hFEDC76_BA9854);
        end
        check("f2_ndone", 64'(done_cnt - d0), 64'd1);

        // Trailer-only frame.
        base = acc_q.size(); d0 = done_cnt;
        start(0);
        check("f0_busy", 64'(busy), 64'd1);
        trailer(48'hAAAA_BBBB_CCCC, 16'h0007);
        step();
        check("f0_npairs", 64'(acc_q.size() - base), 64'd0);
        check("f0_trl", {ticks, buf_ctr}, {48'hAAAA_BBBB_CCCC, 16'h0007});
        check("f0_ndone", 64'(done_cnt - d0), 64'd1);

        // Backpressure: ovfl on second sample's W0, newest pair wins.
        samp_ready = 1'b0;
        start(3);
        sample(24'h111111, 24'h222222);
        check("bp_first", {ovfl, samp_valid}, 64'b01);
        word(16'h3333);
        check("bp_ovfl", 64'(ovfl), 64'd1);
        word(16'h4444); word(16'h3344);
        sample(24'h555555, 24'h666666);
        check("bp_held", {samp_i, samp_q}, 64'h555555_666666);
        trailer(48'h1, 16'h1);
        err_clr = 1'b1; step();
        check("bp_clr", {ovfl, samp_valid}, 64'b01);
        start(2);
        err_clr = 1'b1; word(16'h7777);
        check("bp_clr_vs_set", 64'(ovfl), 64'd1);
        err_clr = 1'b1; step();
        check("bp_clr2", 64'(ovfl), 64'd0);
        start(1);
        check("abort_keeps_pair", {samp_valid, samp_i}, {1'b1, 24'h555555});
        samp_ready = 1'b1; step();

        // Abort after W1, then a fresh one-sample frame.
        base = acc_q.size(); d0 = done_cnt;
        start(2);
        word(16'hDEAD); word(16'hBEEF);
        start(1);
        sample(24'h0ABCDE, 24'hF01234);
        trailer(48'h0102_0304_0506, 16'h0909);
        step();
        check("ab_npairs", 64'(acc_q.size() - base), 64'd1);
        if (acc_q.size() > base) check("ab_pair", 64'(acc_q[base]), 64'h0ABCDE_F01234);
        check("ab_ndone", 64'(done_cnt - d0), 64'd1);
        check("ab_ticks", 64'(ticks), 64'h0102_0304_0506);

        // Reset mid-trailer, then a full frame.
        start(0);
        word(16'h1111); word(16'h2222);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_ctl", {busy, samp_valid, frame_done, ovfl}, 64'd0);
        check("mrst_trl", {ticks, buf_ctr}, 64'd0);
        #3 rst_n = 1'b1;
        step();
        start(1);
        sample(24'hC0FFEE, 24'h123456);
        check("post_rst_pair", {samp_valid, samp_i, samp_q}, {1'b1, 24'hC0FFEE, 24'h123456});
        trailer(48'hFFFF_0000_FFFF, 16'hFFFF);
        check("post_rst_trl", {frame_done, ticks, buf_ctr}, {1'b1, 48'hFFFF_0000_FFFF, 16'hFFFF});

        // Back-to-back words with ready toggling, then randomized frames.
        samp_ready = 1'b1;
        run_frame(4, 0, 2);
        run_frame(5, 0, 2);
        for (int f = 0; f < 30; f++)
            run_frame($urandom_range(0, 5), $urandom_range(0, 2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
